// File: rtl/addr_engine_arbiter_pkg.sv
// Shared definitions for the addressing-engine arbiter: FSM encoding and width defaults
// matching the 640x480, 12-bit-colour frame buffer.
package addr_engine_arbiter_pkg;

   localparam int DEF_X_W    = 10;
   localparam int DEF_Y_W    = 10;
   localparam int DEF_C_W    = 12;
   localparam int DEF_ADDR_W = 17;
   localparam int DEF_OFF_W  = 3;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ISSUE   = 2'd1,
      ARB_WAIT    = 2'd2,
      ARB_DELIVER = 2'd3
   } arb_state_e;

endpackage

// File: rtl/addr_engine_arbiter_rr_select.sv
// rr_priority_select: combinational round-robin pick, searching from last_gnt+1 upward
// with wrap, so the most recently served requester has the lowest priority.
module rr_priority_select #(
   parameter int NUM_REQ = 4,
   parameter int GNT_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GNT_W-1:0]   last_gnt,
   output logic               any,
   output logic [GNT_W-1:0]   winner,
   output logic [NUM_REQ-1:0] onehot
);

   int idx;

   // Walk from the far end of the rotation back toward last_gnt+1 so the
   // highest-priority hit is the final assignment.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      onehot = '0;
      idx    = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_gnt) + k) % NUM_REQ;
         if (req[idx]) begin
            any    = 1'b1;
            winner = GNT_W'(idx);
         end
      end
      if (any) onehot[winner] = 1'b1;
   end

endmodule

// File: rtl/addr_engine_arbiter.sv
// addr_engine_arbiter: time-shares one addressing engine among NUM_REQ draw sources,
// one transaction in flight, result returned on a shared bus to the owning requester.
module addr_engine_arbiter
   import addr_engine_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GNT_W   = 2,
   parameter int X_W     = DEF_X_W,
   parameter int Y_W     = DEF_Y_W,
   parameter int C_W     = DEF_C_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int OFF_W   = DEF_OFF_W
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [NUM_REQ-1:0]     req_rts,
   output logic [NUM_REQ-1:0]     req_rtr,
   input  logic [NUM_REQ*X_W-1:0] req_x,
   input  logic [NUM_REQ*Y_W-1:0] req_y,
   input  logic [NUM_REQ*C_W-1:0] req_color,
   output logic [NUM_REQ-1:0]     rsp_rts,
   input  logic [NUM_REQ-1:0]     rsp_rtr,
   output logic [ADDR_W-1:0]      rsp_addr,
   output logic [OFF_W-1:0]       rsp_offset,
   output logic [C_W-1:0]         rsp_color,
   output logic                   ae_in_rts,
   input  logic                   ae_in_rtr,
   output logic [X_W-1:0]         ae_origx,
   output logic [Y_W-1:0]         ae_origy,
   output logic [C_W-1:0]         ae_color,
   input  logic                   ae_out_rts,
   output logic                   ae_out_rtr,
   input  logic [ADDR_W-1:0]      ae_addr,
   input  logic [OFF_W-1:0]       ae_offset,
   input  logic [C_W-1:0]         ae_out_color,
   output logic                   busy,
   output logic [GNT_W-1:0]       grant_id,
   output logic [15:0]            xact_count
);

   arb_state_e           state;
   logic [GNT_W-1:0]     last_gnt;
   logic [NUM_REQ-1:0]   gnt_vec;
   logic                 sel_any;
   logic [GNT_W-1:0]     sel_idx;
   logic [NUM_REQ-1:0]   sel_onehot;
   logic                 req_xfc;
   logic                 rsp_xfc;

   logic [X_W-1:0] xs [NUM_REQ];
   logic [Y_W-1:0] ys [NUM_REQ];
   logic [C_W-1:0] cs [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign xs[i] = req_x[i*X_W +: X_W];
      assign ys[i] = req_y[i*Y_W +: Y_W];
      assign cs[i] = req_color[i*C_W +: C_W];
   end

   rr_priority_select #(
      .NUM_REQ (NUM_REQ),
      .GNT_W   (GNT_W)
   ) u_sel (
      .req      (req_rts),
      .last_gnt (last_gnt),
      .any      (sel_any),
      .winner   (sel_idx),
      .onehot   (sel_onehot)
   );

   // Accept is offered only from IDLE, and never while reset is asserted.
   assign req_rtr = (rst_ && state == ARB_IDLE && sel_any) ? sel_onehot : '0;
   assign req_xfc = |(req_rtr & req_rts);
   assign rsp_xfc = |(rsp_rts & rsp_rtr);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state      <= ARB_IDLE;
         last_gnt   <= GNT_W'(NUM_REQ - 1);
         gnt_vec    <= '0;
         grant_id   <= '0;
         xact_count <= '0;
         ae_origx   <= '0;
         ae_origy   <= '0;
         ae_color   <= '0;
         rsp_addr   <= '0;
         rsp_offset <= '0;
         rsp_color  <= '0;
         ae_in_rts  <= 1'b0;
         ae_out_rtr <= 1'b0;
         rsp_rts    <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (req_xfc) begin
                  ae_origx  <= xs[sel_idx];
                  ae_origy  <= ys[sel_idx];
                  ae_color  <= cs[sel_idx];
                  grant_id  <= sel_idx;
                  gnt_vec   <= sel_onehot;
                  ae_in_rts <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (ae_in_rtr) begin
                  ae_in_rts  <= 1'b0;
                  ae_out_rtr <= 1'b1;
                  state      <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (ae_out_rts) begin
                  rsp_addr   <= ae_addr;
                  rsp_offset <= ae_offset;
                  rsp_color  <= ae_out_color;
                  ae_out_rtr <= 1'b0;
                  rsp_rts    <= gnt_vec;
                  state      <= ARB_DELIVER;
               end
            end
            ARB_DELIVER: begin
               if (rsp_xfc) begin
                  rsp_rts    <= '0;
                  last_gnt   <= grant_id;
                  xact_count <= xact_count + 16'd1;
                  busy       <= 1'b0;
                  state      <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addr_engine_arbiter.sv
// Bench for addr_engine_arbiter: behavioural 3-cycle addressing engine plus a
// transaction-level reference model of arbitration order, latency and results.
module tb_addr_engine_arbiter;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic [3:0]  req_rts = '0;
   logic [3:0]  req_rtr;
   logic [39:0] req_x;
   logic [39:0] req_y;
   logic [47:0] req_color;
   logic [3:0]  rsp_rts;
   logic [3:0]  rsp_rtr = 4'hF;
   logic [16:0] rsp_addr;
   logic [2:0]  rsp_offset;
   logic [11:0] rsp_color;
   logic        ae_in_rts, ae_in_rtr, ae_out_rts, ae_out_rtr;
   logic [9:0]  ae_origx, ae_origy;
   logic [11:0] ae_color, ae_out_color;
   logic [16:0] ae_addr;
   logic [2:0]  ae_offset;
   logic        busy;
   logic [1:0]  grant_id;
   logic [15:0] xact_count;

   logic [9:0]  px [4];
   logic [9:0]  py [4];
   logic [11:0] pc [4];
   logic [3:0]  hold = '0;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   bit          m_busy = 0;
   int          m_since = 0;
   int          m_g = 0;
   int          m_last = 3;
   int          m_count = 0;
   logic [9:0]  m_x, m_y;
   logic [11:0] m_c;
   int          gnt_log [$];
   logic [16:0] obs_addr;
   logic [2:0]  obs_off;
   logic [11:0] obs_col;

   always #5 clk = ~clk;

   always_comb begin
      req_x = '0; req_y = '0; req_color = '0;
      for (int i = 0; i < 4; i++) begin
         req_x[i*10 +: 10]     = px[i];
         req_y[i*10 +: 10]     = py[i];
         req_color[i*12 +: 12] = pc[i];
      end
   end

   addr_engine_arbiter dut (
      .clk(clk), .rst_(rst_),
      .req_rts(req_rts), .req_rtr(req_rtr),
      .req_x(req_x), .req_y(req_y), .req_color(req_color),
      .rsp_rts(rsp_rts), .rsp_rtr(rsp_rtr),
      .rsp_addr(rsp_addr), .rsp_offset(rsp_offset), .rsp_color(rsp_color),
      .ae_in_rts(ae_in_rts), .ae_in_rtr(ae_in_rtr),
      .ae_origx(ae_origx), .ae_origy(ae_origy), .ae_color(ae_color),
      .ae_out_rts(ae_out_rts), .ae_out_rtr(ae_out_rtr),
      .ae_addr(ae_addr), .ae_offset(ae_offset), .ae_out_color(ae_out_color),
      .busy(busy), .grant_id(grant_id), .xact_count(xact_count)
   );

   // pixel p = y*640+x; eight pixels of 12 bits pack into three 32-bit words
   function automatic logic [16:0] f_addr(logic [9:0] x, logic [9:0] y);
      int p;
      p = int'(y) * 640 + int'(x);
      return 17'((p / 8) * 3);
   endfunction

   function automatic logic [2:0] f_off(logic [9:0] x, logic [9:0] y);
      int p;
      p = int'(y) * 640 + int'(x);
      return 3'(p % 8);
   endfunction

   function automatic int rr_pick(logic [3:0] r, int last);
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   // engine stand-in: accepts when empty, result valid two edges after accept
   logic        e_pend;
   int          e_cnt;
   logic [16:0] e_addr;
   logic [2:0]  e_off;
   logic [11:0] e_col;
   assign ae_in_rtr = !e_pend;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         e_pend <= 1'b0; e_cnt <= 0; ae_out_rts <= 1'b0;
         ae_addr <= '1; ae_offset <= '1; ae_out_color <= '1;
         e_addr <= '0; e_off <= '0; e_col <= '0;
      end else if (ae_in_rts && ae_in_rtr) begin
         e_pend <= 1'b1; e_cnt <= 2;
         e_addr <= f_addr(ae_origx, ae_origy);
         e_off  <= f_off(ae_origx, ae_origy);
         e_col  <= ae_color;
      end else if (ae_out_rts && ae_out_rtr) begin
         ae_out_rts <= 1'b0; e_pend <= 1'b0;
         ae_addr <= '1; ae_offset <= '1; ae_out_color <= '1;
      end else if (e_pend && !ae_out_rts) begin
         if (e_cnt == 1) begin
            ae_out_rts <= 1'b1;
            ae_addr <= e_addr; ae_offset <= e_off; ae_out_color <= e_col;
         end else begin
            e_cnt <= e_cnt - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_since = 0; m_last = 3; m_count = 0;
      req_rts = '0; hold = '0;
   endtask

   // one clock: check everything against the model before the edge, advance model after
   task automatic step();
      int  win;
      bit  hs;
      bit  dlv;
      #1;
      win = (!m_busy && req_rts != 0) ? rr_pick(req_rts, m_last) : -1;
      dlv = m_busy && m_since >= 4;
      hs  = dlv && rsp_rtr[m_g];
      chk("req_rtr", 32'(req_rtr), (win >= 0) ? (32'd1 << win) : 32'd0);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ae_in_rts", 32'(ae_in_rts), 32'(m_busy && m_since == 0));
      chk("ae_out_rtr", 32'(ae_out_rtr), 32'(m_busy && m_since >= 1 && m_since <= 3));
      chk("rsp_rts", 32'(rsp_rts), dlv ? (32'd1 << m_g) : 32'd0);
      chk("xact_count", 32'(xact_count), 32'(m_count & 16'hFFFF));
      if (m_busy) begin
         chk("grant_id", 32'(grant_id), 32'(m_g));
         chk("ae_origx", 32'(ae_origx), 32'(m_x));
         chk("ae_origy", 32'(ae_origy), 32'(m_y));
         chk("ae_color", 32'(ae_color), 32'(m_c));
      end
      if (dlv) begin
         chk("rsp_addr", 32'(rsp_addr), 32'(f_addr(m_x, m_y)));
         chk("rsp_offset", 32'(rsp_offset), 32'(f_off(m_x, m_y)));
         chk("rsp_color", 32'(rsp_color), 32'(m_c));
      end
      if (hs) begin
         obs_addr = rsp_addr; obs_off = rsp_offset; obs_col = rsp_color;
      end
      @(posedge clk); #1;
      if (win >= 0) begin
         m_busy = 1; m_since = 0; m_g = win;
         m_x = px[win]; m_y = py[win]; m_c = pc[win];
         gnt_log.push_back(win);
         if (!hold[win]) req_rts[win] = 1'b0;
      end else if (m_busy) begin
         if (hs) begin
            m_busy = 0; m_last = m_g; m_count++;
         end else begin
            m_since++;
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((m_busy || req_rts != 0) && n < budget) begin
         step();
         n++;
      end
      if (m_busy || req_rts != 0) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic set_req(input int i, input int x, input int y, input int c);
      px[i] = 10'(x); py[i] = 10'(y); pc[i] = 12'(c); req_rts[i] = 1'b1;
   endtask

   task automatic pulse_reset();
      #2 rst_ = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_ = 1'b1;
   endtask

   initial begin
      int cnt0;
      int n;
      for (int i = 0; i < 4; i++) begin px[i] = '0; py[i] = '0; pc[i] = '0; end
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_rts", 32'(rsp_rts), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_xact", 32'(xact_count), 32'd0);
      chk("rst_ae_in_rts", 32'(ae_in_rts), 32'd0);
      @(posedge clk); #1 rst_ = 1'b1;

      // 1: single requester, known address
      set_req(1, 10, 2, 12'hABC);
      drain(40);
      chk("t1_addr", 32'(obs_addr), 32'd483);
      chk("t1_off", 32'(obs_off), 32'd2);
      chk("t1_col", 32'(obs_col), 32'hABC);

      // 2: all four at once after reset -> 0,1,2,3
      pulse_reset();
      gnt_log.delete();
      for (int i = 0; i < 4; i++) set_req(i, 100 * i + 7, 50 * i + 3, 12'h111 * (i + 1));
      drain(80);
      chk("t2_len", 32'(gnt_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("t2_order", 32'(gnt_log[i]), 32'(i));

      // 3: req0 held, req3 arrives mid-flight -> 0,3,0
      gnt_log.delete();
      hold[0] = 1'b1;
      set_req(0, 5, 5, 12'h055);
      step(); step(); step();
      set_req(3, 600, 400, 12'h333);
      n = 0;
      while (gnt_log.size() < 3 && n < 60) begin step(); n++; end
      hold[0] = 1'b0; req_rts[0] = 1'b0;
      drain(40);
      chk("t3_len", 32'(gnt_log.size()), 32'd3);
      if (gnt_log.size() >= 3) begin
         chk("t3_g0", 32'(gnt_log[0]), 32'd0);
         chk("t3_g1", 32'(gnt_log[1]), 32'd3);
         chk("t3_g2", 32'(gnt_log[2]), 32'd0);
      end

      // 4: result stall on requester 2 for 10 cycles
      rsp_rtr = 4'b1011;
      set_req(2, 321, 123, 12'h2F2);
      n = 0;
      while (!(m_busy && m_since >= 4) && n < 20) begin step(); n++; end
      set_req(1, 1, 1, 12'h001);
      repeat (10) step();
      chk("t4_still_deliver", 32'(rsp_rts), 32'b0100);
      rsp_rtr = 4'hF;
      drain(40);

      // 5: screen corners
      cnt0 = m_count;
      set_req(3, 639, 479, 12'hFFF);
      drain(40);
      chk("t5_addr_max", 32'(obs_addr), 32'd115197);
      chk("t5_off_max", 32'(obs_off), 32'd7);
      chk("t5_cnt1", 32'(xact_count), 32'(cnt0 + 1));
      set_req(0, 0, 0, 12'h000);
      drain(40);
      chk("t5_addr_zero", 32'(obs_addr), 32'd0);
      chk("t5_off_zero", 32'(obs_off), 32'd0);
      chk("t5_cnt2", 32'(xact_count), 32'(cnt0 + 2));

      // 6: async reset in WAIT, then 0 beats 2
      set_req(1, 20, 20, 12'h0A0);
      n = 0;
      while (!(m_busy && m_since == 2) && n < 20) begin step(); n++; end
      req_rts = 4'b0101;
      #2 rst_ = 1'b0;
      #1;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_req_rtr", 32'(req_rtr), 32'd0);
      chk("t6_rsp_rts", 32'(rsp_rts), 32'd0);
      chk("t6_ae_out_rtr", 32'(ae_out_rtr), 32'd0);
      chk("t6_ae_in_rts", 32'(ae_in_rts), 32'd0);
      chk("t6_xact", 32'(xact_count), 32'd0);
      chk("t6_grant", 32'(grant_id), 32'd0);
      chk("t6_origx", 32'(ae_origx), 32'd0);
      chk("t6_rsp_addr", 32'(rsp_addr), 32'd0);
      model_reset();
      @(posedge clk); #1 rst_ = 1'b1;
      gnt_log.delete();
      set_req(2, 30, 40, 12'h222);
      set_req(0, 50, 60, 12'h0C0);
      drain(60);
      chk("t6_len", 32'(gnt_log.size()), 32'd2);
      if (gnt_log.size() >= 2) begin
         chk("t6_first", 32'(gnt_log[0]), 32'd0);
         chk("t6_second", 32'(gnt_log[1]), 32'd2);
      end

      // random traffic with random result back-pressure and withdrawn requests
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!req_rts[i] && $urandom_range(3) == 0)
               set_req(i, $urandom_range(639), $urandom_range(479), $urandom_range(4095));
            else if (req_rts[i] && !m_busy && $urandom_range(19) == 0)
               req_rts[i] = 1'b0;
         end
         rsp_rtr = 4'($urandom_range(15));
         step();
      end
      req_rts = '0;
      rsp_rtr = 4'hF;
      drain(40);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
